// File: rtl/spi_master_arbiter.sv
// Round-robin SPI master shared by NUM_REQ requesters, one CS each.
// Runs 8-bit full-duplex LSB-first transfers; optional fixed priority.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   req         : per-requester level request
//   tx_data     : byte per requester, requester i at [8i+7:8i]
//   grant       : one-hot owner of the current transfer
//   done        : one-cycle completion pulse
//   rx_data     : received byte, held until the next done
//   busy        : high from grant until the end of the CS gap
//   SCLK, CS, MOSI, MISO : SPI bus (CS active low, SCLK idle low)
//
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed priority,
// where the lowest set req index always wins.
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] tx_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 done,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 SCLK,
  output logic [NUM_REQ-1:0]   CS,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] cs_q;
  logic               done_q;
  logic               busy_q;
  logic               sclk_q;
  logic               mosi_q;
  logic [7:0]         tx_q;
  logic [7:0]         rx_q;
  logic [7:0]         rxd_q;
  logic [15:0]        div_q;
  logic [15:0]        gap_q;
  // SCLK edges issued so far in this transfer
  logic [3:0]         tog_q;

  logic [PW-1:0]      win_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic               tick;

  assign tick     = (div_q == 16'(CLK_DIV - 1));
  assign win_oh_d = NUM_REQ'(1) << win_d;

`ifdef SPI_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    win_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_d = PW'(i);
    end
  end
`else
  logic [PW-1:0] rr_q;
  logic [PW-1:0] rr_d;

  // First set request at or after the pointer, wrapping.
  always_comb begin
    logic found;
    int   idx;
    win_d = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        win_d = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign rr_d = (win_d == PW'(NUM_REQ - 1))
              ? '0 : win_d + PW'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      cs_q    <= '1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      tog_q   <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= win_oh_d;
            cs_q    <= ~win_oh_d;
            busy_q  <= 1'b1;
            tx_q    <= tx_data[8*win_d +: 8];
            tog_q   <= '0;
            div_q   <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            mosi_q  <= tx_q[0];
            tx_q    <= tx_q >> 1;
            tog_q   <= 4'd1;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        SHIFT: begin
          if (tick) begin
            div_q <= '0;
            tog_q <= tog_q + 4'd1;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              rx_q   <= {MISO, rx_q[7:1]};
              // Sixteenth edge is the eighth fall.
              if (tog_q == 4'd15) begin
                mosi_q  <= 1'b0;
                state_q <= HOLD;
              end
            end else begin
              sclk_q <= 1'b1;
              mosi_q <= tx_q[0];
              tx_q   <= tx_q >> 1;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        HOLD: begin
          if (tick) begin
            div_q   <= '0;
            cs_q    <= '1;
            rxd_q   <= rx_q;
            done_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= GAP;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        GAP: begin
          // grant is kept through the done cycle only
          grant_q <= '0;
          if (gap_q == 16'(CS_GAP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rx_data = rxd_q;
  assign busy    = busy_q;
  assign SCLK    = sclk_q;
  assign CS      = cs_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: vector table plus corner sequences.
// Two instances: CLK_DIV=2 (u0) and CLK_DIV=1 (u1).
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [3:0]  req0 = '0;
  logic [31:0] tx0 = '0;
  logic [3:0]  grant0, cs0;
  logic        done0, busy0, sclk0, mosi0;
  logic [7:0]  rx0;
  logic        miso0 = 1'b0;

  logic [3:0]  req1 = '0;
  logic [31:0] tx1 = '0;
  logic [3:0]  grant1, cs1;
  logic        done1, busy1, sclk1, mosi1;
  logic [7:0]  rx1;
  logic        miso1 = 1'b0;

  spi_master_arbiter #(
    .NUM_REQ(4), .CLK_DIV(2), .CS_GAP(2)
  ) u0 (
    .clk(clk), .reset(rst), .req(req0),
    .tx_data(tx0), .grant(grant0),
    .done(done0), .rx_data(rx0),
    .busy(busy0), .SCLK(sclk0), .CS(cs0),
    .MOSI(mosi0), .MISO(miso0)
  );

  spi_master_arbiter #(
    .NUM_REQ(4), .CLK_DIV(1), .CS_GAP(2)
  ) u1 (
    .clk(clk), .reset(rst), .req(req1),
    .tx_data(tx1), .grant(grant1),
    .done(done1), .rx_data(rx1),
    .busy(busy1), .SCLK(sclk1), .CS(cs1),
    .MOSI(mosi1), .MISO(miso1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Slave models: load on CS fall, drive MISO after SCLK rise,
  // shift in the MOSI value held before each SCLK fall.
  logic [7:0] sbyte0 = '0, sreg0 = '0;
  logic [7:0] sbyte1 = '0, sreg1 = '0;
  logic       sp0 = 0, mp0 = 0, sp1 = 0, mp1 = 0;
  logic [3:0] cp0 = 4'hF, cp1 = 4'hF;
  int         lrise1 = -1, per1 = 0;

  always @(negedge clk) begin
    if (cp0 == 4'hF && cs0 != 4'hF) sreg0 = sbyte0;
    if (!sp0 && sclk0) miso0 = sreg0[0];
    if (sp0 && !sclk0) sreg0 = {mp0, sreg0[7:1]};
    sp0 = sclk0; mp0 = mosi0; cp0 = cs0;
  end

  always @(negedge clk) begin
    if (cp1 == 4'hF && cs1 != 4'hF) sreg1 = sbyte1;
    if (!sp1 && sclk1) begin
      miso1 = sreg1[0];
      if (lrise1 >= 0) per1 = cyc - lrise1;
      lrise1 = cyc;
    end
    if (sp1 && !sclk1) sreg1 = {mp1, sreg1[7:1]};
    sp1 = sclk1; mp1 = mosi1; cp1 = cs1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick1();
    tick1();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int s,
                            output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 100; i++) begin
      tick1();
      g = (s != 0) ? grant1 : grant0;
      if (g != 0) break;
    end
  endtask

  task automatic wait_done(input int s,
                           output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick1();
      if ((s != 0) ? done1 : done0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      tick1();
      if (!busy0) break;
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] sl;
    logic [3:0] exp_grant;
    logic [7:0] exp_rx;
    logic [7:0] exp_slv;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [3:0] g;
    logic       ok;
    logic       csbad;
    logic       sawd;
    int         t0;
    int         hi;
    int         r;
    logic       prev;
    logic [3:0] exp3[5];

    vt[0] = '{1, 8'hA5, 8'h3C, 4'b0010, 8'h3C, 8'hA5};
    vt[1] = '{0, 8'h5A, 8'hC3, 4'b0001, 8'hC3, 8'h5A};
    vt[2] = '{3, 8'h81, 8'h7E, 4'b1000, 8'h7E, 8'h81};
    vt[3] = '{2, 8'h00, 8'hFF, 4'b0100, 8'hFF, 8'h00};
    vt[4] = '{1, 8'hFF, 8'h01, 4'b0010, 8'h01, 8'hFF};

`ifdef SPI_ARB_FIXED_PRIO_EN
    exp3 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
    exp3 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`endif

    tick1();
    tick1();
    chk("rst_cs", 32'(cs0), 32'hF);
    chk("rst_sclk", 32'(sclk0), 0);
    chk("rst_mosi", 32'(mosi0), 0);
    chk("rst_grant", 32'(grant0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_rx", 32'(rx0), 0);
    rst = 1'b0;

    // single transfers from the vector table
    foreach (vt[k]) begin
      tx0 = '0;
      tx0[8*vt[k].idx +: 8] = vt[k].tx;
      sbyte0 = vt[k].sl;
      req0 = 4'b0001 << vt[k].idx;
      wait_grant(0, g);
      chk("v_grant", 32'(g), 32'(vt[k].exp_grant));
      t0 = cyc;
      csbad = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick1();
        if (done0) begin
          ok = 1'b1;
          break;
        end
        if (cs0 !== ~vt[k].exp_grant) csbad = 1'b1;
      end
      chk("v_done", 32'(ok), 1);
      chk("v_latency", 32'(cyc - t0), 34);
      chk("v_cs_low", 32'(csbad), 0);
      chk("v_cs_done", 32'(cs0), 32'hF);
      chk("v_grant_done", 32'(grant0),
          32'(vt[k].exp_grant));
      chk("v_rx", 32'(rx0), 32'(vt[k].exp_rx));
      req0 = '0;
      wait_idle();
      chk("v_slave", 32'(sreg0), 32'(vt[k].exp_slv));
      chk("v_mosi_idle", 32'(mosi0), 0);
    end

    // simultaneous req[0] and req[2]
    do_reset();
    req0 = 4'b0101;
    wait_grant(0, g);
    chk("sim_first", 32'(g), 32'h1);
    wait_done(0, ok);
    chk("sim_done1", 32'(ok), 1);
    req0 = 4'b0100;
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      tick1();
      if (cs0 == 4'hF) hi++;
      else break;
    end
    chk("sim_second", 32'(grant0), 32'h4);
    chk("sim_gap", 32'(hi >= 2), 1);
    wait_done(0, ok);
    chk("sim_done2", 32'(ok), 1);
    req0 = '0;
    wait_idle();

    // all four held continuously
    do_reset();
    req0 = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_grant(0, g);
      chk("all_grant", 32'(g), 32'(exp3[n]));
      wait_done(0, ok);
      chk("all_done", 32'(ok), 1);
      tick1();
    end
    req0 = '0;
    wait_idle();

    // reset after the 5th SCLK rise
    do_reset();
    req0 = 4'b0010;
    wait_grant(0, g);
    chk("ra_grant", 32'(g), 32'h2);
    prev = sclk0;
    r = 0;
    for (int i = 0; i < 200; i++) begin
      tick1();
      if (sclk0 && !prev) r++;
      prev = sclk0;
      if (r == 5) break;
    end
    chk("ra_rises", 32'(r), 5);
    rst = 1'b1;
    req0 = '0;
    tick1();
    chk("ra_cs", 32'(cs0), 32'hF);
    chk("ra_sclk", 32'(sclk0), 0);
    chk("ra_grant0", 32'(grant0), 0);
    chk("ra_busy", 32'(busy0), 0);
    rst = 1'b0;
    sawd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick1();
      if (done0) sawd = 1'b1;
    end
    chk("ra_nodone", 32'(sawd), 0);
    req0 = 4'b0101;
    wait_grant(0, g);
    chk("ra_next", 32'(g), 32'h1);
    wait_done(0, ok);
    chk("ra_done", 32'(ok), 1);
    req0 = '0;
    wait_idle();

    // req[3] dropped mid-transfer
    req0 = 4'b1000;
    wait_grant(0, g);
    chk("drop_grant", 32'(g), 32'h8);
    t0 = cyc;
    repeat (4) tick1();
    req0 = '0;
    wait_done(0, ok);
    chk("drop_done", 32'(ok), 1);
    chk("drop_lat", 32'(cyc - t0), 34);
    chk("drop_gdone", 32'(grant0), 32'h8);
    wait_idle();

    // CLK_DIV=1 back-to-back
    tx1 = 32'h0000_00FF;
    sbyte1 = 8'h00;
    req1 = 4'b0001;
    wait_grant(1, g);
    chk("d1_grant", 32'(g), 32'h1);
    t0 = cyc;
    wait_done(1, ok);
    chk("d1_done", 32'(ok), 1);
    chk("d1_lat", 32'(cyc - t0), 17);
    chk("d1_rx", 32'(rx1), 32'h00);
    chk("d1_slave", 32'(sreg1), 32'hFF);
    chk("d1_period", 32'(per1), 2);
    tx1 = 32'h0;
    sbyte1 = 8'hFF;
    tick1();
    wait_grant(1, g);
    chk("d1_grant2", 32'(g), 32'h1);
    wait_done(1, ok);
    chk("d1_done2", 32'(ok), 1);
    chk("d1_rx2", 32'(rx1), 32'hFF);
    req1 = '0;
    repeat (6) tick1();
    chk("d1_slave2", 32'(sreg1), 32'h00);
    chk("d1_busy", 32'(busy1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Single SPI master that shares one SCLK/MOSI/MISO bus among NUM_REQ requesters, each owning one slave chip-select. Arbitrates pending requests round-robin, runs one 8-bit full-duplex LSB-first transfer on the granted requester's CS, and returns the received byte. Sits between on-chip clients and the SPI slaves. Bus timing matches our slaves: they drive MISO on SCLK rise and sample MOSI on SCLK fall.

Parameters:
NUM_REQ, 4, number of requesters and chip-selects (2..8)
CLK_DIV, 2, SCLK half-period H in clk cycles (>=1)
CS_GAP, 2, minimum clk cycles CS stays high between transfers (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req  in  NUM_REQ  per-requester transfer request, level
tx_data  in  8*NUM_REQ  byte to send; requester i uses bits [8i+7:8i]
grant  out  NUM_REQ  one-hot owner of the current transfer
done  out  1  one-cycle pulse: transfer of the granted requester is complete
rx_data  out  8  received byte, valid from the done cycle until the next done
busy  out  1  high from grant until end of the CS gap
SCLK  out  1  SPI clock, idle low
CS  out  NUM_REQ  active-low chip-selects, idle all high
MOSI  out  1  master data out
MISO  in  1  slave data in

Behaviour:
- Reset on a clk edge with reset=1: CS all 1, SCLK=0, MOSI=0, grant=0, done=0, busy=0, rx_data=0, state=IDLE, RR pointer=0. Any in-progress transfer is aborted with no done pulse.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: if any req bit is set, the winner is the first set bit at or after the RR pointer, wrapping. On that edge (T0): grant[w]=1, CS[w]=0, busy=1, tx shift reg<=tx_data[w], bit counter=0, RR pointer<=(w+1) mod NUM_REQ. Next state is SETUP.
- SETUP: H cycles with CS low and SCLK low. At T0+H: SCLK=1, MOSI=tx bit0. Next state is SHIFT.
- SHIFT: SCLK toggles every H cycles.
  - Falling toggle: rx shift reg<={MISO, rx[7:1]}.
  - Rising toggle: MOSI=next tx bit, LSB first.
  - 8 rises at T0+H, 3H, ... 15H; 8th fall at T0+16H. Next state is HOLD.
- HOLD: SCLK low, CS low, for H cycles. At T0+17H: CS[w]=1, rx_data<=rx shift reg, done=1 for one cycle, grant stays valid in that cycle and clears on the next edge. Next state is GAP.
- GAP: CS all high for CS_GAP cycles. busy drops on the edge entering IDLE. New arbitration is possible only from IDLE.
- Handshake: a requester holds req and tx_data stable until it sees done with its grant bit. tx_data is sampled only at T0. Dropping req mid-transfer has no effect: the transfer completes and done still pulses. req still high after done counts as a new request.
- Simultaneous requests: exactly one grant; the others wait and are never lost.
- MOSI returns to 0 in HOLD/IDLE. MISO is sampled as-is (z/x propagates).

Optional Feature:
SPI_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest set req index always wins; the RR pointer is removed.
- Undefined (default): round-robin as above.

Test Plan:
1. CLK_DIV=2, single req[1], tx_data[1]=0xA5, slave 1 loaded 0x3C -> CS[1] low 34 cycles (T0..T0+34), done at T0+34, rx_data=0x3C, slave receives 0xA5, other CS stay high.
2. req[0] and req[2] raised in the same cycle, held -> grant 0 first, then grant 2, with CS high for >=CS_GAP cycles between. Same with SPI_ARB_FIXED_PRIO_EN.
3. All four req held continuously -> grant order 0,1,2,3,0. Under SPI_ARB_FIXED_PRIO_EN, grant is always 0.
4. reset asserted after the 5th SCLK rise -> next edge: CS=4'b1111, SCLK=0, grant=0, busy=0; no done pulse; the next transfer goes to requester 0.
5. req[3] dropped after T0+4 -> transfer completes, done pulses at T0+34 with grant[3]=1.
6. CLK_DIV=1, tx 0xFF / slave 0x00 then tx 0x00 / slave 0xFF back-to-back -> rx_data 0x00 then 0xFF, SCLK period 2 clk cycles.
